// File: rtl/cdf_lut_builder.sv
// Histogram-equalizer CDF stage: finds cdf_min over scratchpad m2, then builds the
// 256-entry equalization LUT in m3 using a fixed-latency restoring divider.
module cdf_lut_builder #(
  parameter int unsigned NUM_PIXELS = 64,
  parameter logic [15:0] TAG        = 16'hAAAA
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m2ReadAddr,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         m3WE,
  output logic         done
);

  localparam int unsigned DIV_STEPS = 24;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MIN_ADDR = 3'd1;
  localparam logic [2:0] S_MIN_DATA = 3'd2;
  localparam logic [2:0] S_MAP_ADDR = 3'd3;
  localparam logic [2:0] S_MAP_DATA = 3'd4;
  localparam logic [2:0] S_DIV      = 3'd5;
  localparam logic [2:0] S_WRITE    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]  state_q,   state_d;
  logic [7:0]  bin_q,     bin_d;
  logic [15:0] cdf_q,     cdf_d;
  logic [15:0] cdf_min_q, cdf_min_d;
  logic [23:0] num_q,     num_d;
  logic [15:0] den_q,     den_d;
  logic [15:0] rem_q,     rem_d;
  logic [23:0] quo_q,     quo_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  waddr_q,   waddr_d;
  logic [31:0] wval_q,    wval_d;
  logic        we_q,      we_d;
  logic        done_q,    done_d;

  logic [15:0] count;
  logic [16:0] cdf_sum;
  logic [15:0] cdf_new;
  logic [15:0] cdf_diff;
  logic [23:0] num_c;
  logic [15:0] den_c;
  logic [16:0] rem_sh;
  logic        qbit;
  logic [15:0] rem_nx;
  logic [23:0] quo_nx;
  logic [7:0]  map_c;
  logic        unused_hi;

  assign unused_hi = ^m2ReadVal[127:32];

  // Untagged words were never written by the input stage, so they count as empty bins
  assign count    = (m2ReadVal[31:16] == TAG) ? m2ReadVal[15:0] : 16'h0000;
  assign cdf_sum  = 17'(cdf_q) + 17'(count);
  assign cdf_new  = cdf_sum[16] ? 16'hFFFF : cdf_sum[15:0];
  assign cdf_diff = cdf_new - cdf_min_q;
  assign num_c    = (cdf_new >= cdf_min_q) ? 24'(cdf_diff) * 24'd255 : 24'h000000;
  assign den_c    = 16'(NUM_PIXELS) - cdf_min_q;

  // One restoring-division step; a zero divisor yields quotient bits of 0
  assign rem_sh = {rem_q, num_q[23]};
  assign qbit   = (den_q != 16'h0000) && (rem_sh >= {1'b0, den_q});
  assign rem_nx = qbit ? 16'(rem_sh - {1'b0, den_q}) : rem_sh[15:0];
  assign quo_nx = {quo_q[22:0], qbit};
  assign map_c  = (|quo_nx[23:8]) ? 8'hFF : quo_nx[7:0];

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    cdf_d     = cdf_q;
    cdf_min_d = cdf_min_q;
    num_d     = num_q;
    den_d     = den_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_cnt_d = div_cnt_q;
    waddr_d   = waddr_q;
    wval_d    = wval_q;
    we_d      = 1'b0;
    done_d    = done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MIN_ADDR;
          bin_d   = 8'd0;
          cdf_d   = 16'h0000;
          done_d  = 1'b0;
        end
      end
      S_MIN_ADDR: state_d = S_MIN_DATA;
      S_MIN_DATA: begin
        if (count != 16'h0000) begin
          cdf_min_d = count;
          bin_d     = 8'd0;
          state_d   = S_MAP_ADDR;
        end else if (bin_q == 8'd255) begin
          cdf_min_d = 16'h0000;
          bin_d     = 8'd0;
          state_d   = S_MAP_ADDR;
        end else begin
          bin_d   = bin_q + 8'd1;
          state_d = S_MIN_ADDR;
        end
      end
      S_MAP_ADDR: state_d = S_MAP_DATA;
      S_MAP_DATA: begin
        cdf_d     = cdf_new;
        num_d     = num_c;
        den_d     = den_c;
        rem_d     = 16'h0000;
        quo_d     = 24'h000000;
        div_cnt_d = 5'd0;
        state_d   = S_DIV;
      end
      S_DIV: begin
        num_d     = {num_q[22:0], 1'b0};
        rem_d     = rem_nx;
        quo_d     = quo_nx;
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'(DIV_STEPS - 1)) begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          waddr_d = bin_q;
          wval_d  = {TAG, 8'h00, map_c};
        end
      end
      S_WRITE: begin
        if (bin_q == 8'd255) begin
          state_d = S_DONE;
        end else begin
          bin_d   = bin_q + 8'd1;
          state_d = S_MAP_ADDR;
        end
      end
      S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          cdf_d   = 16'h0000;
          bin_d   = 8'd0;
          state_d = S_MIN_ADDR;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bin_q     <= 8'd0;
      cdf_q     <= 16'h0000;
      cdf_min_q <= 16'h0000;
      num_q     <= 24'h000000;
      den_q     <= 16'h0000;
      rem_q     <= 16'h0000;
      quo_q     <= 24'h000000;
      div_cnt_q <= 5'd0;
      waddr_q   <= 8'd0;
      wval_q    <= 32'h0000_0000;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      cdf_q     <= cdf_d;
      cdf_min_q <= cdf_min_d;
      num_q     <= num_d;
      den_q     <= den_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_cnt_q <= div_cnt_d;
      waddr_q   <= waddr_d;
      wval_q    <= wval_d;
      we_q      <= we_d;
      done_q    <= done_d;
    end
  end

  assign m2ReadAddr  = {8'h00, bin_q};
  assign m3WriteAddr = {8'h00, waddr_q};
  assign m3WriteVal  = {96'h0, wval_q};
  assign m3WE        = we_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cdf_lut_builder.sv
// Directed bench for cdf_lut_builder: behavioural m2 memory, m3 write capture,
// hand-computed LUT values and operation latencies.
module tb_cdf_lut_builder;

  localparam logic [15:0] TAG = 16'hAAAA;

  logic         clock;
  logic         rst_n;
  logic         start;
  logic [127:0] m2ReadVal;
  logic [15:0]  m2ReadAddr;
  logic [15:0]  m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic         m3WE;
  logic         done;

  logic [127:0] mem [256];
  logic [7:0]   lut [256];
  int n_checks;
  int n_err;
  int wr_cnt;
  int order_bad;
  int fmt_bad;
  int tag_bad;
  int done_first;
  int cyc;
  int bad;
  int pulses;

  cdf_lut_builder #(.NUM_PIXELS(64), .TAG(TAG)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .m2ReadVal  (m2ReadVal),
    .m2ReadAddr (m2ReadAddr),
    .m3WriteAddr(m3WriteAddr),
    .m3WriteVal (m3WriteVal),
    .m3WE       (m3WE),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read scratchpad: data valid the cycle after the address
  always @(posedge clock) m2ReadVal <= mem[m2ReadAddr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int b = 0; b < 256; b++) mem[b] = 128'h0;
  endtask

  // Start an operation, capture m3 writes at negedges, return cycles from start edge to done
  task automatic run_op(input int hold, output int cycles);
    int c;
    c = 0;
    wr_cnt = 0; order_bad = 0; fmt_bad = 0; tag_bad = 0; done_first = -1;
    for (int b = 0; b < 256; b++) lut[b] = 8'h5A;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    while (c < 8000) begin
      @(negedge clock);
      if (c >= hold) start = 1'b0;
      if (done_first < 0) done_first = int'(done);
      if (m3WE) begin
        if (m3WriteAddr !== 16'(wr_cnt)) order_bad++;
        if (m3WriteVal[31:16] !== TAG) tag_bad++;
        if (m3WriteVal[127:32] !== 96'h0 || m3WriteVal[15:8] !== 8'h00) fmt_bad++;
        lut[m3WriteAddr[7:0]] = m3WriteVal[7:0];
        wr_cnt++;
      end
      if (done) break;
      @(posedge clock);
      c++;
    end
    start = 1'b0;
    cycles = c;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0;
    clear_mem();
    #23;
    chk("reset_m2addr", 32'(m2ReadAddr), 32'd0);
    chk("reset_we", 32'(m3WE), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_m3addr", 32'(m3WriteAddr), 32'd0);
    chk("reset_m3val", 32'(|m3WriteVal), 32'd0);
    @(negedge clock) rst_n = 1'b1;

    // Uniform histogram: bins 0..63 hold 1, upper junk bits on one word must be ignored
    for (int b = 0; b < 64; b++) mem[b] = {96'h0, TAG, 16'd1};
    mem[3] = {96'hDEAD_BEEF_0123_4567_89AB_CDEF, TAG, 16'd1};

    // Abort in the middle of bin 10's divide (DIV spans cycles 274..297 after start)
    wr_cnt = 0;
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    cyc = 0;
    while (cyc < 280) begin
      @(negedge clock);
      start = 1'b0;
      if (m3WE) wr_cnt++;
      @(posedge clock);
      cyc++;
    end
    @(negedge clock);
    chk("middiv_writes_before", 32'(wr_cnt), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("middiv_m2addr", 32'(m2ReadAddr), 32'd0);
    chk("middiv_we", 32'(m3WE), 32'd0);
    chk("middiv_done", 32'(done), 32'd0);
    chk("middiv_m3addr", 32'(m3WriteAddr), 32'd0);
    chk("middiv_m3val", 32'(|m3WriteVal), 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (m3WE) pulses++;
    end
    chk("middiv_no_pulse", 32'(pulses), 32'd0);
    rst_n = 1'b1;

    run_op(0, cyc);
    chk("uni_cycles", 32'(cyc), 32'(2 * 1 + 256 * 27 + 1));
    chk("uni_writes", 32'(wr_cnt), 32'd256);
    chk("uni_order", 32'(order_bad), 32'd0);
    chk("uni_format", 32'(fmt_bad + tag_bad), 32'd0);
    chk("uni_map0", 32'(lut[0]), 32'd0);
    chk("uni_map1", 32'(lut[1]), 32'd4);
    chk("uni_map31", 32'(lut[31]), 32'd125);
    chk("uni_map62", 32'(lut[62]), 32'd250);
    chk("uni_map63", 32'(lut[63]), 32'd255);
    chk("uni_map64", 32'(lut[64]), 32'd255);
    chk("uni_map255", 32'(lut[255]), 32'd255);
    bad = 0;
    for (int b = 0; b < 256; b++)
      if (lut[b] !== ((b <= 63) ? 8'((b * 255) / 63) : 8'd255)) bad++;
    chk("uni_map_all", 32'(bad), 32'd0);
    for (int i = 0; i < 3; i++) @(negedge clock);
    chk("uni_done_held", 32'(done), 32'd1);

    // Single-value image: den is zero, every entry maps to 0
    clear_mem();
    mem[100] = {96'h0, TAG, 16'd64};
    run_op(0, cyc);
    chk("single_cycles", 32'(cyc), 32'(2 * 101 + 256 * 27 + 1));
    chk("single_writes", 32'(wr_cnt), 32'd256);
    chk("single_order", 32'(order_bad), 32'd0);
    bad = 0;
    for (int b = 0; b < 256; b++) if (lut[b] !== 8'd0) bad++;
    chk("single_map_all", 32'(bad), 32'd0);

    // Two values at the extremes, start held high well into the run
    clear_mem();
    mem[0]   = {96'h0, TAG, 16'd32};
    mem[255] = {96'h0, TAG, 16'd32};
    run_op(500, cyc);
    chk("two_cycles", 32'(cyc), 32'(2 * 1 + 256 * 27 + 1));
    chk("two_writes", 32'(wr_cnt), 32'd256);
    chk("two_order", 32'(order_bad), 32'd0);
    chk("two_map254", 32'(lut[254]), 32'd0);
    chk("two_map255", 32'(lut[255]), 32'd255);
    bad = 0;
    for (int b = 0; b < 256; b++) if (lut[b] !== ((b == 255) ? 8'd255 : 8'd0)) bad++;
    chk("two_map_all", 32'(bad), 32'd0);

    // Restart from DONE: done drops right away, identical LUT is rebuilt
    run_op(0, cyc);
    chk("restart_done_drop", 32'(done_first), 32'd0);
    chk("restart_cycles", 32'(cyc), 32'(2 * 1 + 256 * 27 + 1));
    chk("restart_writes", 32'(wr_cnt), 32'd256);
    bad = 0;
    for (int b = 0; b < 256; b++) if (lut[b] !== ((b == 255) ? 8'd255 : 8'd0)) bad++;
    chk("restart_map_all", 32'(bad), 32'd0);

    // Empty histogram, with untagged junk words carrying nonzero low counts
    clear_mem();
    mem[5]   = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h1234, 16'd7};
    mem[200] = {96'h0, 16'hAAAB, 16'd5};
    run_op(0, cyc);
    chk("empty_cycles", 32'(cyc), 32'(2 * 256 + 256 * 27 + 1));
    chk("empty_writes", 32'(wr_cnt), 32'd256);
    chk("empty_tag", 32'(tag_bad), 32'd0);
    chk("empty_format", 32'(fmt_bad + order_bad), 32'd0);
    bad = 0;
    for (int b = 0; b < 256; b++) if (lut[b] !== 8'd0) bad++;
    chk("empty_map_all", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
